// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared types and constants for the instruction-memory loader.
// Holds the FSM state enum, WORD_BYTES and the default program-length limit.
package imem_loader_pkg;

   localparam int WORD_BYTES    = 4;
   localparam int ADDR_W_DEF    = 8;
   localparam int MAX_WORDS_DEF = 64;

   // CHK only exists when the trailing checksum byte is part of the protocol.
   typedef enum logic [2:0] {
      S_IDLE,
      S_HDR,
      S_DATA,
      S_WRITE,
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHK,
`endif
      S_DONE,
      S_ERR
   } state_t;

endpackage

// File: rtl/imem_byte_packer.sv
// imem_byte_packer: gathers host bytes little-endian into a 32-bit word.
// Ports: clk, reset (async, active-low), clear, push, byte_in -> word_next, last.
module imem_byte_packer
   import imem_loader_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        clear,
   input  logic        push,
   input  logic [7:0]  byte_in,
   output logic [31:0] word_next,
   output logic        last
);

   logic [1:0]  cnt_q;
   logic [31:0] word_q;

   // Shift right so the first byte of a word ends up in bits [7:0].
   assign word_next = {byte_in, word_q[31:8]};
   assign last      = push && (cnt_q == 2'(WORD_BYTES - 1));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q  <= '0;
         word_q <= '0;
      end else if (clear) begin
         cnt_q  <= '0;
         word_q <= '0;
      end else if (push) begin
         cnt_q  <= cnt_q + 2'd1;
         word_q <= word_next;
      end
   end

endmodule

// File: rtl/imem_loader.sv
// imem_loader: streams a length-prefixed program from a host into imem.
// Ports: clk, reset, load_en, byte_valid/byte_data/byte_ready (host side),
// wr_en/wr_addr/wr_data (imem side), core_hold, done, err.
// Optional trailing checksum byte: define IMEM_LOADER_CHECKSUM_EN.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int ADDR_W    = ADDR_W_DEF,
   parameter int MAX_WORDS = MAX_WORDS_DEF
)(
   input  logic              clk,
   input  logic              reset,
   input  logic              load_en,
   input  logic              byte_valid,
   input  logic [7:0]        byte_data,
   output logic              byte_ready,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [31:0]       wr_data,
   output logic              core_hold,
   output logic              done,
   output logic              err
);

   localparam int IDX_W = ADDR_W - 2;

   state_t           state_q;
   logic [IDX_W-1:0] idx_q;
   logic [7:0]       left_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [7:0]       csum_q;
`endif

   logic        xfer;
   logic        hdr_ok;
   logic        pk_push;
   logic        pk_clear;
   logic        pk_last;
   logic [31:0] pk_word;

   assign xfer   = byte_valid && byte_ready;
   assign hdr_ok = (byte_data != 8'd0) &&
                   ({24'd0, byte_data} <= 32'(MAX_WORDS));

   // Packer only runs in DATA; anywhere else its partial word is dropped.
   assign pk_push  = (state_q == S_DATA) && xfer && load_en;
   assign pk_clear = (state_q != S_DATA);

   imem_byte_packer u_packer (
      .clk       (clk),
      .reset     (reset),
      .clear     (pk_clear),
      .push      (pk_push),
      .byte_in   (byte_data),
      .word_next (pk_word),
      .last      (pk_last)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= S_IDLE;
         idx_q      <= '0;
         left_q     <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
         csum_q     <= '0;
`endif
         byte_ready <= 1'b0;
         wr_en      <= 1'b0;
         wr_addr    <= '0;
         wr_data    <= '0;
         core_hold  <= 1'b0;
         done       <= 1'b0;
         err        <= 1'b0;
      end else begin
         wr_en <= 1'b0;
         if (!load_en && state_q != S_IDLE) begin
            // Abort or release; a strobe already on wr_en is not extended.
            state_q    <= S_IDLE;
            byte_ready <= 1'b0;
            core_hold  <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
         end else begin
            case (state_q)
               S_IDLE: begin
                  if (load_en) begin
                     state_q    <= S_HDR;
                     byte_ready <= 1'b1;
                     core_hold  <= 1'b1;
                     idx_q      <= '0;
                     wr_addr    <= '0;
                  end
               end
               S_HDR: begin
                  if (xfer) begin
                     left_q <= byte_data;
`ifdef IMEM_LOADER_CHECKSUM_EN
                     csum_q <= byte_data;
`endif
                     if (hdr_ok) begin
                        state_q <= S_DATA;
                     end else begin
                        state_q    <= S_ERR;
                        byte_ready <= 1'b0;
                        err        <= 1'b1;
                     end
                  end
               end
               S_DATA: begin
                  if (xfer) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                     csum_q <= csum_q + byte_data;
`endif
                     if (pk_last) begin
                        state_q    <= S_WRITE;
                        byte_ready <= 1'b0;
                        wr_en      <= 1'b1;
                        wr_addr    <= {idx_q, 2'b00};
                        wr_data    <= pk_word;
                     end
                  end
               end
               S_WRITE: begin
                  if (left_q == 8'd1) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                     state_q    <= S_CHK;
                     byte_ready <= 1'b1;
`else
                     state_q   <= S_DONE;
                     core_hold <= 1'b0;
                     done      <= 1'b1;
`endif
                  end else begin
                     state_q    <= S_DATA;
                     byte_ready <= 1'b1;
                     idx_q      <= idx_q + 1'b1;
                     left_q     <= left_q - 8'd1;
                  end
               end
`ifdef IMEM_LOADER_CHECKSUM_EN
               S_CHK: begin
                  if (xfer) begin
                     byte_ready <= 1'b0;
                     if (byte_data == csum_q) begin
                        state_q   <= S_DONE;
                        core_hold <= 1'b0;
                        done      <= 1'b1;
                     end else begin
                        state_q <= S_ERR;
                        err     <= 1'b1;
                     end
                  end
               end
`endif
               S_DONE: begin
                  state_q <= S_DONE;
               end
               S_ERR: begin
                  state_q <= S_ERR;
               end
               default: begin
                  state_q    <= S_IDLE;
                  byte_ready <= 1'b0;
                  core_hold  <= 1'b0;
                  done       <= 1'b0;
                  err        <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed + randomized bench for imem_loader.
// Expected writes come from a byte-list model of the load protocol.
module tb_imem_loader;

`ifdef IMEM_LOADER_CHECKSUM_EN
   localparam bit CSUM = 1'b1;
`else
   localparam bit CSUM = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        load_en = 1'b0;
   logic        byte_valid = 1'b0;
   logic [7:0]  byte_data = 8'd0;
   logic        byte_ready;
   logic        wr_en;
   logic [7:0]  wr_addr;
   logic [31:0] wr_data;
   logic        core_hold;
   logic        done;
   logic        err;

   always #5 clk = ~clk;

   imem_loader dut (
      .clk        (clk),
      .reset      (reset),
      .load_en    (load_en),
      .byte_valid (byte_valid),
      .byte_data  (byte_data),
      .byte_ready (byte_ready),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .core_hold  (core_hold),
      .done       (done),
      .err        (err)
   );

   typedef struct {
      logic [7:0]  a;
      logic [31:0] d;
   } wr_t;

   wr_t        wq[$];
   wr_t        eq[$];
   logic [7:0] dq[$];
   int         n_vec = 0;
   int         n_err = 0;
   int         stall_cnt = 0;
   int         bad_cnt = 0;

   always @(negedge clk) begin
      if (wr_en) wq.push_back('{wr_addr, wr_data});
      if (core_hold && !byte_ready && !err) stall_cnt++;
      if (wr_en && (byte_ready || wr_addr[1:0] != 2'b00)) bad_cnt++;
   end

   task automatic check(input string tag, input logic [63:0] obs,
                        input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic fill_random(input int n);
      dq.delete();
      for (int i = 0; i < 4 * n; i++) dq.push_back(8'($urandom));
   endtask

   // Word w is bytes 4w..4w+3, first byte least significant, at address 4w.
   task automatic build_model(input int n);
      eq.delete();
      for (int w = 0; w < n; w++) begin
         eq.push_back('{8'(4 * w),
            {dq[4*w+3], dq[4*w+2], dq[4*w+1], dq[4*w]}});
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input bit gaps);
      if (gaps && $urandom_range(0, 3) == 0) begin
         byte_valid = 1'b0;
         repeat ($urandom_range(1, 3)) @(negedge clk);
      end
      byte_valid = 1'b1;
      byte_data  = b;
      for (int i = 0; i < 64 && !byte_ready; i++) @(negedge clk);
      if (!byte_ready) check("ready_timeout", byte_ready, 1'b1);
      @(negedge clk);
   endtask

   task automatic cmp_writes(input string tag);
      int m;
      check({tag, "_nwr"}, wq.size(), eq.size());
      m = (wq.size() < eq.size()) ? wq.size() : eq.size();
      for (int i = 0; i < m; i++) begin
         check({tag, "_addr"}, wq[i].a, eq[i].a);
         check({tag, "_data"}, wq[i].d, eq[i].d);
      end
   endtask

   task automatic do_load(input int n, input bit gaps, input bit bad_sum,
                          input string tag);
      bit         ok_hdr;
      bit         exp_done;
      logic [7:0] sum;
      ok_hdr   = (n >= 1) && (n <= 64);
      exp_done = ok_hdr && !(bad_sum && CSUM);
      wq.delete();
      eq.delete();
      if (ok_hdr) build_model(n);
      load_en = 1'b1;
      send_byte(8'(n), gaps);
      sum = 8'(n);
      if (ok_hdr) begin
         foreach (dq[i]) begin
            send_byte(dq[i], gaps);
            sum = sum + dq[i];
         end
         if (CSUM) send_byte(bad_sum ? sum + 8'd1 : sum, gaps);
      end
      byte_valid = 1'b0;
      for (int i = 0; i < 20 && !(done || err); i++) @(negedge clk);
      repeat (3) @(negedge clk);
      check({tag, "_done"}, done, exp_done);
      check({tag, "_err"}, err, !exp_done);
      check({tag, "_hold"}, core_hold, !exp_done);
      check({tag, "_rdy"}, byte_ready, 1'b0);
      cmp_writes(tag);
      load_en = 1'b0;
      @(negedge clk);
      check({tag, "_rel"}, {done, err, core_hold, byte_ready}, 4'b0);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check("rst_ctl", {byte_ready, wr_en, core_hold, done, err}, 5'b0);
      check("rst_addr", wr_addr, 8'h00);
      check("rst_data", wr_data, 32'h0);
      reset = 1'b1;
      @(negedge clk);

      // Two-word program with known encodings.
      dq = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
      do_load(2, 1'b0, 1'b0, "n2");
      if (wq.size() >= 2) begin
         check("n2_w0", wq[0].d, 32'h0000_0013);
         check("n2_w1", wq[1].d, 32'h0010_0093);
      end

      // Illegal headers.
      dq.delete();
      do_load(0, 1'b0, 1'b0, "hdr0");
      do_load(65, 1'b0, 1'b0, "hdr65");

      // Abort after 6 data bytes of a 3-word program.
      fill_random(3);
      build_model(3);
      wq.delete();
      load_en = 1'b1;
      send_byte(8'd3, 1'b0);
      for (int i = 0; i < 6; i++) send_byte(dq[i], 1'b0);
      byte_valid = 1'b0;
      load_en = 1'b0;
      repeat (4) @(negedge clk);
      check("abort_nwr", wq.size(), 1);
      if (wq.size() >= 1) begin
         check("abort_addr", wq[0].a, 8'h00);
         check("abort_data", wq[0].d, eq[0].d);
      end
      check("abort_idle", {done, err, core_hold, byte_ready}, 4'b0);

      // Full-size program with byte_valid never dropped.
      fill_random(64);
      stall_cnt = 0;
      bad_cnt = 0;
      do_load(64, 1'b0, 1'b0, "n64");
      check("n64_stalls", stall_cnt, 64);
      check("n64_overlap", bad_cnt, 0);

      // Random lengths and host gaps.
      for (int k = 0; k < 6; k++) begin
         int n;
         n = $urandom_range(1, 12);
         fill_random(n);
         do_load(n, 1'b1, 1'b0, "rnd");
      end

      if (CSUM) begin
         dq = '{8'h01, 8'h02, 8'h03, 8'h04};
         do_load(1, 1'b0, 1'b0, "csum_ok");
         do_load(1, 1'b0, 1'b1, "csum_bad");
      end

      // Reset in the middle of DATA.
      fill_random(4);
      load_en = 1'b1;
      send_byte(8'd4, 1'b0);
      for (int i = 0; i < 5; i++) send_byte(dq[i], 1'b0);
      byte_valid = 1'b0;
      #2 reset = 1'b0;
      #1 check("rst_async", {byte_ready, wr_en, core_hold, done, err,
                             wr_addr, wr_data}, 45'd0);
      load_en = 1'b0;
      wq.delete();
      repeat (3) @(negedge clk);
      check("rst_nowr", wq.size(), 0);
      reset = 1'b1;
      @(negedge clk);
      fill_random(1);
      do_load(1, 1'b0, 1'b0, "after_rst");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
